// File: rtl/serial_seq_tx_pkg.sv
// serial_tx_pkg: shared state encoding and line constants for the serial transmitter.
package serial_tx_pkg;
  typedef enum logic [2:0] {IDLE = 3'b001, SEND = 3'b010, GAP = 3'b100} tx_state_t;
  localparam logic IDLE_LEVEL = 1'b0;
  localparam int MAX_GAP = 15;
endpackage

// File: rtl/serial_seq_tx_if.sv
// serial_seq_tx_if: load/ready handshake plus serial line bundle.
interface serial_seq_tx_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] data;
  logic load;
  logic ready;
  logic x;
  logic busy;
  logic done;
  modport master(output data, load, input ready, x, busy, done);
  modport slave(input data, load, output ready, x, busy, done);
endinterface

// File: rtl/serial_seq_tx_down_counter.sv
// down_counter: loadable down counter that saturates at zero.
module down_counter #(parameter int W = 4) (
  input  logic         ck,
  input  logic         r,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         zero
);
  assign zero = q == '0;
  always_ff @(posedge ck) begin
    if (r) q <= '0;
    else if (ld) q <= ld_val;
    else if (en && !zero) q <= q - 1'b1;
  end
endmodule

// File: rtl/serial_seq_tx.sv
// serial_seq_tx: MSB-first serial transmitter with idle-low gap between frames.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit to every frame.
module serial_seq_tx
  import serial_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input logic          ck,
  input logic          r,
  serial_seq_tx_if.slave s
);
`ifdef SERIAL_TX_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  localparam int GL = GAP > 0 ? GAP - 1 : 0;
  tx_state_t state, nxt;
  logic [FL-1:0] sr, cap;
  logic bz, gz, accept, bit_end;
`ifdef SERIAL_TX_PARITY_EN
  // parity travels as the final shift-register bit, taken from the captured word
  assign cap = {s.data, ^s.data};
`else
  assign cap = s.data;
`endif
  assign accept  = state == IDLE && s.load;
  assign bit_end = state == SEND && bz;
  down_counter #(.W(CW)) u_bit (
    .ck(ck), .r(r), .ld(accept), .ld_val(CW'(FL - 1)),
    .en(state == SEND), .q(), .zero(bz)
  );
  down_counter #(.W(4)) u_gap (
    .ck(ck), .r(r), .ld(bit_end), .ld_val(4'(GL)),
    .en(state == serial_tx_pkg::GAP), .q(), .zero(gz)
  );
  always_ff @(posedge ck) begin
    if (r) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge ck) begin
    if (r) sr <= '0;
    else if (accept) sr <= cap;
    else if (state == SEND) sr <= {sr[FL-2:0], 1'b0};
  end
  always_comb begin
    nxt = IDLE;
    nxt = state == IDLE ? (s.load ? SEND : IDLE)
        : state == SEND ? (bz ? (GAP > 0 ? serial_tx_pkg::GAP : IDLE) : SEND)
        : state == serial_tx_pkg::GAP ? (gz ? IDLE : serial_tx_pkg::GAP)
        : IDLE;
  end
  assign s.x     = state == SEND ? sr[FL-1] : IDLE_LEVEL;
  assign s.ready = state == IDLE;
  assign s.busy  = state != IDLE;
  assign s.done  = bit_end;
endmodule

// File: tb/tb_serial_seq_tx.sv
// tb_serial_seq_tx: drives GAP=0 and GAP=1 instances in lockstep against a frame-level model.
module tb_serial_seq_tx;
  logic ck = 0, r = 1, load = 0;
  logic [7:0] data = 0;
  int n_tests = 0, n_fail = 0;
  logic [8:0] fr[2];
  int nb[2], rem[2];
  always #5 ck = ~ck;
  serial_seq_tx_if #(.WIDTH(8)) a0();
  serial_seq_tx_if #(.WIDTH(8)) a1();
  assign a0.data = data;
  assign a0.load = load;
  assign a1.data = data;
  assign a1.load = load;
  serial_seq_tx #(.WIDTH(8), .GAP(0)) u0 (.ck(ck), .r(r), .s(a0));
  serial_seq_tx #(.WIDTH(8), .GAP(1)) u1 (.ck(ck), .r(r), .s(a1));
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  // per instance k (gap length k): frame bits left to send and cycles until ready
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        nb[k] = 0;
        rem[k] = 0;
      end else if (rem[k] == 0) begin
        if (load) begin
`ifdef SERIAL_TX_PARITY_EN
          fr[k] = {data, ^data};
          nb[k] = 9;
`else
          fr[k] = {1'b0, data};
          nb[k] = 8;
`endif
          rem[k] = nb[k] + k;
        end
      end else begin
        if (nb[k] > 0) nb[k]--;
        rem[k]--;
      end
    end
  endtask
  function automatic logic exp_x(int k);
    return nb[k] > 0 ? fr[k][nb[k]-1] : 1'b0;
  endfunction
  task automatic step();
    @(posedge ck);
    model_edge();
    #1;
    check("x_gap0", a0.x, exp_x(0));
    check("ready_gap0", a0.ready, rem[0] == 0);
    check("busy_gap0", a0.busy, rem[0] != 0);
    check("done_gap0", a0.done, nb[0] == 1);
    check("x_gap1", a1.x, exp_x(1));
    check("ready_gap1", a1.ready, rem[1] == 0);
    check("busy_gap1", a1.busy, rem[1] != 0);
    check("done_gap1", a1.done, nb[1] == 1);
  endtask
  task automatic drive(logic rr, logic ll, logic [7:0] dd, int n);
    r = rr;
    load = ll;
    data = dd;
    repeat (n) step();
  endtask
  initial begin
    drive(1, 0, 8'h00, 2);
    drive(0, 0, 8'h00, 10);
    drive(0, 1, 8'hD6, 1);
    drive(0, 0, 8'hD6, 2);
    drive(0, 1, 8'hFF, 1);
    drive(0, 0, 8'h00, 12);
    drive(0, 1, 8'hA5, 1);
    drive(0, 1, 8'h3C, 20);
    drive(0, 0, 8'h00, 12);
    drive(0, 1, 8'hF0, 1);
    drive(0, 0, 8'hF0, 3);
    drive(1, 1, 8'h55, 1);
    drive(0, 0, 8'h00, 5);
    drive(0, 1, 8'hB1, 1);
    drive(0, 0, 8'h00, 12);
    drive(0, 1, 8'h07, 1);
    drive(0, 0, 8'h00, 12);
    repeat (300) drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, 8'($urandom), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
